// File: rtl/darkflash_pkg.sv
// darkflash_pkg: shared types and constants for the darkflash SPI flash
// read bridge.
//   state_t           : transaction FSM states
//   DEFAULT_FLASH_CMD : SPI READ opcode used unless overridden
//   CMD_BITS/ADDR_END/DATA_END : cumulative bit-counter phase boundaries
//   BIT_W / DIV_W     : widths of the bit counter and the SCK divider
//   swap_bytes()      : reverses byte order of a 32-bit word
package darkflash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE,
    GUARD
  } state_t;

  localparam logic [7:0] DEFAULT_FLASH_CMD = 8'h03;

  localparam int CMD_BITS = 8;
  localparam int ADDR_END = 32;
  localparam int DATA_END = 64;

  localparam int BIT_W = 6;
  localparam int DIV_W = 8;

  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/darkflash_sckgen.sv
// darkflash_sckgen: SPI mode-0 clock generator.
//   clk   : system clock (XCLK)
//   rst_n : asynchronous active-low reset
//   run   : high while chip select is asserted; low forces SCK idle low
//   sck   : SPI clock, toggles every CLKDIV clk cycles while run is high
//   rise  : single-cycle strobe, SCK goes high at the next clk edge
//   fall  : single-cycle strobe, SCK goes low at the next clk edge
module darkflash_sckgen
  import darkflash_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  // The strobes announce the toggle that the coming edge will perform, so
  // the parent can act on the same edge that moves SCK.
  assign wrap = run && (div_cnt == DIV_LAST);
  assign rise = wrap && !sck;
  assign fall = wrap && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/darkflash.sv
// darkflash: memory-mapped read-only bridge to a SPI NOR flash.
// A read (enable && RD while idle) issues READ opcode + 24-bit word-aligned
// address, clocks in 32 data bits and returns them little-endian.
//   XCLK, XRES      : clock, asynchronous active-low reset
//   enable, RD, WR  : decoder select, read strobe, write strobe (ignored)
//   addr            : flash-relative byte address (bits 23:2 used)
//   data_o, ready   : read word, one-cycle valid pulse
//   busy            : transaction in flight (including deselect guard)
//   spi_cs_n, spi_sck, spi_mosi, spi_miso : SPI mode-0 flash pins
module darkflash
  import darkflash_pkg::*;
#(
  parameter int         CLKDIV    = 2,
  parameter logic [7:0] FLASH_CMD = DEFAULT_FLASH_CMD
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        enable,
  input  logic        RD,
  input  logic        WR,
  input  logic [31:0] addr,
  output logic [31:0] data_o,
  output logic        ready,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [BIT_W-1:0] CMD_LAST  = BIT_W'(CMD_BITS - 1);
  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_END - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_END - 1);

  state_t           state, next_state;
  logic [BIT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] guard_cnt;
  logic [31:0]      tx_sr;
  logic [31:0]      rx_sr;
  logic             run, start, sck_rise, sck_fall;
  logic             unused_inputs;

  // Flash is read-only and word-addressed inside a 16 MiB window.
  assign unused_inputs = ^{WR, addr[31:24], addr[1:0]};

  assign busy     = (state != IDLE);
  assign start    = enable && RD && !busy;
  assign run      = (state == CMD) || (state == ADDR) || (state == DATA);
  assign spi_mosi = tx_sr[31];

  darkflash_sckgen #(.CLKDIV(CLKDIV)) u_sckgen (
    .clk   (XCLK),
    .rst_n (XRES),
    .run   (run),
    .sck   (spi_sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) state <= IDLE;
    else       state <= next_state;
  end

  // Phase changes happen on the falling SCK that closes each phase's last bit.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CMD;
      CMD:     if (sck_fall && bit_cnt == CMD_LAST)  next_state = ADDR;
      ADDR:    if (sck_fall && bit_cnt == ADDR_LAST) next_state = DATA;
      DATA:    if (sck_fall && bit_cnt == DATA_LAST) next_state = DONE;
      DONE:    next_state = GUARD;
      GUARD:   if (guard_cnt == DIV_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      bit_cnt   <= '0;
      guard_cnt <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      data_o    <= '0;
      ready     <= 1'b0;
      spi_cs_n  <= 1'b1;
    end else begin
      ready <= 1'b0;
      if (state == IDLE && start) begin
        // Opcode and address go out as one 32-bit MSB-first stream; the
        // first bit is presented together with chip-select assertion.
        tx_sr    <= {FLASH_CMD, addr[23:2], 2'b00};
        bit_cnt  <= '0;
        spi_cs_n <= 1'b0;
      end
      if (sck_rise && state == DATA) rx_sr <= {rx_sr[30:0], spi_miso};
      if (sck_fall) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
        if (state != DATA) tx_sr <= {tx_sr[30:0], 1'b0};
      end
      if (state == DATA && next_state == DONE) begin
        // rx_sr holds the first byte in its top lane; flip to little-endian.
        spi_cs_n <= 1'b1;
        ready    <= 1'b1;
        data_o   <= swap_bytes(rx_sr);
      end
      if (state == DONE)       guard_cnt <= '0;
      else if (state == GUARD) guard_cnt <= guard_cnt + DIV_W'(1);
    end
  end

endmodule
